// File: rtl/order_n_pipe.sv
// order_n_pipe
//   Pipelined stable sorter built as an odd-even transposition network.
//   It has NUM registered stages. Stage k compares and exchanges the lane
//   pairs that start at lane (k % 2): stage 0 works on (0,1),(2,3),..., and
//   stage 1 works on (1,2),(3,4),... NUM such rounds fully sort NUM lanes.
//   Each element carries a tag holding its original input position. Each
//   sample carries its own ascending/descending mode bit.
//
// Ports
//   clock       rising-edge clock
//   rst         asynchronous active-high reset; clears every stage register
//   in_valid    indata/in_descend carry a sample this cycle
//   in_descend  0 = ascending, 1 = descending (travels with the sample)
//   hold        freezes every stage register; inputs are ignored while high
//   indata      NUM packed elements, element i at [i*DSIZE +: DSIZE]
//   out_valid   outdata/outidx carry a sorted sample
//   outdata     sorted elements, lane i at [i*DSIZE +: DSIZE]
//   outidx      original input position of each outdata lane
module order_n_pipe #(
  parameter int DSIZE = 8,
  parameter int NUM   = 8,
  parameter int ISIZE = $clog2(NUM)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_descend,
  input  logic                   hold,
  input  logic [NUM*DSIZE-1:0]   indata,
  output logic                   out_valid,
  output logic [NUM*DSIZE-1:0]   outdata,
  output logic [NUM*ISIZE-1:0]   outidx
);

  // stage registers, one entry per stage
  logic [NUM*DSIZE-1:0] stg_d [NUM];
  logic [NUM*ISIZE-1:0] stg_t [NUM];
  logic                 stg_m [NUM];
  logic                 stg_v [NUM];

  for (genvar k = 0; k < NUM; k++) begin : g_stage
    logic [NUM*DSIZE-1:0] src_d;
    logic [NUM*ISIZE-1:0] src_t;
    logic                 src_m;
    logic                 src_v;
    logic [NUM*DSIZE-1:0] cx_d;
    logic [NUM*ISIZE-1:0] cx_t;
    logic [DSIZE-1:0]     lo;
    logic [DSIZE-1:0]     hi;
    logic [ISIZE-1:0]     lo_t;
    logic [ISIZE-1:0]     hi_t;
    logic                 swap;

    // Stage 0 both captures the sample and performs the first even round,
    // so NUM stages give the NUM rounds a full sort needs.
    if (k == 0) begin : g_src
      always_comb begin
        src_d = indata;
        src_t = '0;
        for (int i = 0; i < NUM; i++) begin
          src_t[i*ISIZE +: ISIZE] = ISIZE'(i);
        end
        src_m = in_descend;
        src_v = in_valid;
      end
    end else begin : g_src
      always_comb begin
        src_d = stg_d[k-1];
        src_t = stg_t[k-1];
        src_m = stg_m[k-1];
        src_v = stg_v[k-1];
      end
    end

    // Only strictly out-of-order pairs swap. Equal neighbours stay put, so
    // the sort is stable and each tag moves together with its data.
    always_comb begin
      cx_d = src_d;
      cx_t = src_t;
      lo   = '0;
      hi   = '0;
      lo_t = '0;
      hi_t = '0;
      swap = 1'b0;
      for (int i = k % 2; i < NUM - 1; i += 2) begin
        lo   = src_d[i*DSIZE +: DSIZE];
        hi   = src_d[(i+1)*DSIZE +: DSIZE];
        lo_t = src_t[i*ISIZE +: ISIZE];
        hi_t = src_t[(i+1)*ISIZE +: ISIZE];
        swap = src_m ? (lo < hi) : (lo > hi);
        if (swap) begin
          cx_d[i*DSIZE +: DSIZE]     = hi;
          cx_d[(i+1)*DSIZE +: DSIZE] = lo;
          cx_t[i*ISIZE +: ISIZE]     = hi_t;
          cx_t[(i+1)*ISIZE +: ISIZE] = lo_t;
        end
      end
    end

    // Bubbles advance like real samples; only the valid bit tells them apart.
    always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
        stg_d[k] <= '0;
        stg_t[k] <= '0;
        stg_m[k] <= 1'b0;
        stg_v[k] <= 1'b0;
      end else if (!hold) begin
        stg_d[k] <= cx_d;
        stg_t[k] <= cx_t;
        stg_m[k] <= src_m;
        stg_v[k] <= src_v;
      end
    end
  end

  assign out_valid = stg_v[NUM-1];
  assign outdata   = stg_d[NUM-1];
  assign outidx    = stg_t[NUM-1];

endmodule

// File: tb/tb_order_n_pipe.sv
// tb_order_n_pipe
//   Directed checks of order_n_pipe with NUM=4 and DSIZE=8, followed by a
//   randomized run that is compared against an insertion-sort reference.
//   Inputs change on the falling edge. Outputs are sampled on the falling
//   edge, before the inputs for the next rising edge are applied.
module tb_order_n_pipe;

  localparam int DSIZE = 8;
  localparam int NUM   = 4;
  localparam int ISIZE = 2;

  logic                 clock = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_descend;
  logic                 hold;
  logic [NUM*DSIZE-1:0] indata;
  logic                 out_valid;
  logic [NUM*DSIZE-1:0] outdata;
  logic [NUM*ISIZE-1:0] outidx;

  int errors = 0;
  int checks = 0;

  order_n_pipe #(.DSIZE(DSIZE), .NUM(NUM), .ISIZE(ISIZE)) dut (
    .clock      (clock),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_descend (in_descend),
    .hold       (hold),
    .indata     (indata),
    .out_valid  (out_valid),
    .outdata    (outdata),
    .outidx     (outidx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Packs four lane values; lane 0 sits in the low bits.
  function automatic logic [31:0] pk(input logic [7:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [7:0] pki(input logic [1:0] i0, i1, i2, i3);
    return {i3, i2, i1, i0};
  endfunction

  task automatic issue(input logic [31:0] d, input logic desc);
    indata     = d;
    in_descend = desc;
    in_valid   = 1'b1;
  endtask

  // Stable reference sort; returns {outidx, outdata}.
  function automatic logic [39:0] ref_sort(input logic [31:0] d, input logic desc);
    logic [7:0] v [4];
    logic [1:0] t [4];
    logic [7:0] tv;
    logic [1:0] tt;
    logic [31:0] od;
    logic [7:0]  oi;
    for (int i = 0; i < 4; i++) begin
      v[i] = d[i*8 +: 8];
      t[i] = 2'(i);
    end
    for (int i = 1; i < 4; i++) begin
      for (int j = i; j > 0; j--) begin
        if (desc ? (v[j-1] < v[j]) : (v[j-1] > v[j])) begin
          tv = v[j]; v[j] = v[j-1]; v[j-1] = tv;
          tt = t[j]; t[j] = t[j-1]; t[j-1] = tt;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      od[i*8 +: 8] = v[i];
      oi[i*2 +: 2] = t[i];
    end
    return {oi, od};
  endfunction

  logic [39:0] exp_q [$];
  logic [39:0] e;
  logic [31:0] rd;
  logic        rm;

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_descend = 1'b0;
    hold       = 1'b0;
    indata     = '0;
    cyc();
    cyc();
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_data",  64'(outdata),   64'(0));
    chk("reset_idx",   64'(outidx),    64'(0));
    rst = 1'b0;
    cyc();

    // ascending {7,2,9,0}
    issue(pk(7, 2, 9, 0), 1'b0);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("asc_lat_early", 64'(out_valid), 64'(0));
    cyc();
    chk("asc_valid", 64'(out_valid), 64'(1));
    chk("asc_data",  64'(outdata),   64'(pk(0, 2, 7, 9)));
    chk("asc_idx",   64'(outidx),    64'(pki(3, 1, 0, 2)));
    cyc();
    chk("asc_one_cycle", 64'(out_valid), 64'(0));

    // descending stability {5,3,5,8}
    issue(pk(5, 3, 5, 8), 1'b1);
    cyc();
    in_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("desc_valid", 64'(out_valid), 64'(1));
    chk("desc_data",  64'(outdata),   64'(pk(8, 5, 5, 3)));
    chk("desc_idx",   64'(outidx),    64'(pki(3, 0, 2, 1)));

    // back-to-back, mixed mode
    issue(pk(1, 2, 3, 4), 1'b0);
    cyc();
    issue(pk(1, 2, 3, 4), 1'b1);
    cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    chk("b2b_a_valid", 64'(out_valid), 64'(1));
    chk("b2b_a_data",  64'(outdata),   64'(pk(1, 2, 3, 4)));
    chk("b2b_a_idx",   64'(outidx),    64'(pki(0, 1, 2, 3)));
    cyc();
    chk("b2b_d_valid", 64'(out_valid), 64'(1));
    chk("b2b_d_data",  64'(outdata),   64'(pk(4, 3, 2, 1)));
    chk("b2b_d_idx",   64'(outidx),    64'(pki(3, 2, 1, 0)));
    cyc();
    chk("b2b_after", 64'(out_valid), 64'(0));

    // hold for three edges while the sample is in flight
    issue(pk(3, 1, 2, 0), 1'b0);
    cyc();
    in_valid = 1'b0;
    hold     = 1'b1;
    issue(pk(9, 9, 9, 9), 1'b1);  // ignored while held
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_inflight_valid", 64'(out_valid), 64'(0));
    end
    hold     = 1'b0;
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("hold_lat_early", 64'(out_valid), 64'(0));
    cyc();
    chk("hold_valid", 64'(out_valid), 64'(1));
    chk("hold_data",  64'(outdata),   64'(pk(0, 1, 2, 3)));
    chk("hold_idx",   64'(outidx),    64'(pki(3, 1, 2, 0)));
    hold = 1'b1;
    cyc();
    cyc();
    chk("hold_frozen_valid", 64'(out_valid), 64'(1));
    chk("hold_frozen_data",  64'(outdata),   64'(pk(0, 1, 2, 3)));
    hold = 1'b0;
    cyc();
    chk("hold_release", 64'(out_valid), 64'(0));

    // reset mid-flight, asserted together with hold
    issue(pk(4, 3, 2, 1), 1'b0);
    cyc();
    issue(pk(8, 7, 6, 5), 1'b0);
    cyc();
    in_valid = 1'b0;
    #2;
    hold = 1'b1;
    rst  = 1'b1;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'(0));
    cyc();
    chk("rst_data", 64'(outdata), 64'(0));
    chk("rst_idx",  64'(outidx),  64'(0));
    rst  = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rst_discard", 64'(out_valid), 64'(0));
    end
    issue(pk(6, 0, 6, 1), 1'b1);
    cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    chk("rst_new_early", 64'(out_valid), 64'(0));
    cyc();
    chk("rst_new_valid", 64'(out_valid), 64'(1));
    chk("rst_new_data",  64'(outdata),   64'(pk(6, 6, 1, 0)));
    chk("rst_new_idx",   64'(outidx),    64'(pki(0, 2, 3, 1)));
    cyc();

    // randomized run against the reference sort
    for (int n = 0; n < 10000; ) begin
      hold = ($urandom_range(0, 9) < 2);
      if (out_valid && !hold) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_valid", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rand_sample", 64'({outidx, outdata}), 64'(e));
        end
      end
      in_valid = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) rd[i*8 +: 8] = 8'($urandom_range(0, 10));
      rm         = 1'($urandom_range(0, 1));
      indata     = rd;
      in_descend = rm;
      if (in_valid && !hold) begin
        exp_q.push_back(ref_sort(rd, rm));
        n++;
      end
      cyc();
    end
    hold     = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < NUM + 2; i++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("drain_unexpected_valid", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("drain_sample", 64'({outidx, outdata}), 64'(e));
        end
      end
      cyc();
    end
    chk("rand_all_emerged", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
